// File: rtl/result_sender.sv
// result_sender: streams a result vector out of a read buffer, one byte per element, through a
// UART transmitter handshake (TX_START / TX_BUSY).
// Optional feature macro FRAME_HEADER_EN: wraps every non-empty frame with a 0xFE header byte
// and a 0xEF tail byte, so a frame is size+2 bytes. Undefined (default): frames are size bytes.
module result_sender #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned SIZE_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SIZE_M_EN,
   input  logic [7:0]        REC_DATA,
   input  logic              START,
   input  logic              CLEAR,
   input  logic [DATA_W-1:0] RD_DATA,
   input  logic              TX_BUSY,
   output logic [SIZE_W-1:0] RD_ADDR,
   output logic              RD_EN,
   output logic [DATA_W-1:0] TX_DATA,
   output logic              TX_START,
   output logic              BUSY,
   output logic              DONE
);

`ifdef FRAME_HEADER_EN
   typedef enum logic [2:0] {
      StIdle, StRead, StLatch, StSend, StWaitTx, StFinish, StHeader, StTail
   } state_e;
   // What the byte in flight belongs to, so WAIT_TX knows where to go next.
   typedef enum logic [1:0] {KData, KHead, KTail} kind_e;
   kind_e kind_q, kind_d;
`else
   typedef enum logic [2:0] {
      StIdle, StRead, StLatch, StSend, StWaitTx, StFinish
   } state_e;
`endif

   localparam logic [SIZE_W-1:0] IdxOne = SIZE_W'(1);

   state_e            state_q, state_d;
   logic [SIZE_W-1:0] idx_q, idx_d;
   logic [SIZE_W-1:0] size_q, size_d;
   logic [SIZE_W-1:0] rd_addr_q, rd_addr_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic              first_q, first_d;   // first WAIT_TX cycle, TX_BUSY not yet valid
   logic              done_q, done_d;
   logic              unused_rec;

   assign unused_rec = ^REC_DATA[7:SIZE_W];

   // Read index is driven live during READ and holds its last value otherwise.
   assign RD_ADDR = RD_EN ? idx_q : rd_addr_q;
   assign TX_DATA = tx_data_q;
   assign BUSY    = (state_q != StIdle);
   assign DONE    = done_q;

   // Next-state, datapath updates and strobe outputs; CLEAR overrides everything.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      size_d    = size_q;
      rd_addr_d = rd_addr_q;
      tx_data_d = tx_data_q;
      first_d   = 1'b0;
      done_d    = 1'b0;
      RD_EN     = 1'b0;
      TX_START  = 1'b0;
`ifdef FRAME_HEADER_EN
      kind_d    = kind_q;
`endif
      if (CLEAR) begin
         state_d   = StIdle;
         idx_d     = '0;
         size_d    = '0;
         tx_data_d = '0;
`ifdef FRAME_HEADER_EN
         kind_d    = KData;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (SIZE_M_EN) size_d = REC_DATA[SIZE_W-1:0];
               if (START) begin
                  idx_d = '0;
                  if (size_q == '0) begin
                     state_d = StFinish;
                  end else begin
`ifdef FRAME_HEADER_EN
                     state_d = StHeader;
`else
                     state_d = StRead;
`endif
                  end
               end
            end
            StRead: begin
               RD_EN     = 1'b1;
               rd_addr_d = idx_q;
               state_d   = StLatch;
            end
            StLatch: begin
               tx_data_d = RD_DATA;
               state_d   = StSend;
            end
            StSend: begin
               if (!TX_BUSY) begin
                  TX_START = 1'b1;
                  first_d  = 1'b1;
                  state_d  = StWaitTx;
               end
            end
            StWaitTx: begin
               if (!first_q && !TX_BUSY) begin
`ifdef FRAME_HEADER_EN
                  if (kind_q == KHead) begin
                     kind_d  = KData;
                     state_d = StRead;
                  end else if (kind_q == KTail) begin
                     kind_d  = KData;
                     state_d = StFinish;
                  end else
`endif
                  if (idx_q == size_q - IdxOne) begin
                     idx_d = '0;
`ifdef FRAME_HEADER_EN
                     state_d = StTail;
`else
                     state_d = StFinish;
`endif
                  end else begin
                     idx_d   = idx_q + IdxOne;
                     state_d = StRead;
                  end
               end
            end
            StFinish: begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
`ifdef FRAME_HEADER_EN
            StHeader: begin
               tx_data_d = DATA_W'(8'hFE);
               kind_d    = KHead;
               state_d   = StSend;
            end
            StTail: begin
               tx_data_d = DATA_W'(8'hEF);
               kind_d    = KTail;
               state_d   = StSend;
            end
`endif
            default: state_d = StIdle;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         size_q    <= '0;
         rd_addr_q <= '0;
         tx_data_q <= '0;
         first_q   <= 1'b0;
         done_q    <= 1'b0;
`ifdef FRAME_HEADER_EN
         kind_q    <= KData;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         size_q    <= size_d;
         rd_addr_q <= rd_addr_d;
         tx_data_q <= tx_data_d;
         first_q   <= first_d;
         done_q    <= done_d;
`ifdef FRAME_HEADER_EN
         kind_q    <= kind_d;
`endif
      end
   end

endmodule

// File: doc/result_sender.md
RESULT_SENDER -- requirements
Module: result_sender

Interface
REQ-001 Parameter: DATA_W, 8, width of result elements and UART bytes.
REQ-002 Parameter: SIZE_W, 4, width of matrix size and read index.
REQ-003 The block SHALL use a single clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  system clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 SIZE_M_EN  in  1  load matrix size from REC_DATA[SIZE_W-1:0].
REQ-007 REC_DATA  in  8  size byte from UART receive path.
REQ-008 START  in  1  single-cycle request to transmit the result vector.
REQ-009 CLEAR  in  1  synchronous abort and clear.
REQ-010 RD_DATA  in  DATA_W  result buffer read data, valid one cycle after RD_EN.
REQ-011 TX_BUSY  in  1  UART transmitter busy; rises the cycle after TX_START and stays high until the byte is sent.
REQ-012 RD_ADDR  out  SIZE_W  result buffer read index.
REQ-013 RD_EN  out  1  result buffer read strobe.
REQ-014 TX_DATA  out  DATA_W  byte presented to the UART transmitter, registered.
REQ-015 TX_START  out  1  one-cycle transmit request.
REQ-016 BUSY  out  1  high in every state except IDLE.
REQ-017 DONE  out  1  one-cycle pulse when the frame completes.

Function
REQ-018 States SHALL be IDLE, READ, LATCH, SEND, WAIT_TX and FINISH, plus HEADER and TAIL when FRAME_HEADER_EN is defined.
REQ-019 IDLE: SIZE_M_EN SHALL load the size register; SIZE_M_EN SHALL be ignored in every other state.
REQ-020 IDLE + START with size > 0 SHALL set idx=0 and go to READ, or to HEADER if FRAME_HEADER_EN is defined.
REQ-021 IDLE + START with size == 0 SHALL go directly to FINISH; no RD_EN and no TX_START are issued, and no header is sent.
REQ-022 READ: RD_EN=1 and RD_ADDR=idx for exactly one cycle, then go to LATCH.
REQ-023 LATCH: TX_DATA <= RD_DATA, then go to SEND; read-to-byte latency is 2 cycles.
REQ-024 SEND: if TX_BUSY==0, pulse TX_START for one cycle and go to WAIT_TX; otherwise hold in SEND.
REQ-025 WAIT_TX: TX_BUSY SHALL be ignored in the first cycle; the state exits on the first later cycle with TX_BUSY==0.
REQ-026 WAIT_TX exit rule: if idx == size-1, clear idx and go to TAIL (macro defined) or FINISH; else idx += 1 and go to READ.
REQ-027 FINISH: pulse DONE for one cycle and return to IDLE.
REQ-028 START while BUSY=1 SHALL be ignored.
REQ-029 Elements SHALL be sent in ascending index order, 0 to size-1, one byte each.
REQ-030 RD_ADDR SHALL hold its last value when RD_EN=0.
REQ-031 CLEAR SHALL have priority over all other inputs: return to IDLE and zero idx, size, TX_DATA, TX_START and DONE; an in-flight UART byte is not recalled.
REQ-032 START and CLEAR in the same cycle: CLEAR wins and no transmission starts.

Reset
REQ-033 On rst=0: state=IDLE, idx=0, size=0, RD_ADDR=0, RD_EN=0, TX_DATA=0, TX_START=0, BUSY=0, DONE=0, asynchronously.
REQ-034 Reset mid-frame SHALL abandon the frame; after release the block stays in IDLE until the next START.

Configuration
REQ-035 Macro FRAME_HEADER_EN.
REQ-036 When defined, HEADER SHALL send 0xFE and TAIL SHALL send 0xEF, each using the SEND/WAIT_TX handshake, giving frames of size+2 bytes.
REQ-037 When undefined, HEADER and TAIL SHALL not exist and frames are exactly size bytes.

Verification
REQ-038 Load size=3; buffer holds {0x11,0x22,0x33}; START with TX_BUSY held high 10 cycles per byte -> TX_DATA sequence 0x11,0x22,0x33 (plus 0xFE first and 0xEF last if the macro is defined), then one DONE pulse.
REQ-039 Size=0, START -> DONE pulse 2 cycles later; RD_EN and TX_START never assert.
REQ-040 TX_BUSY forced high at SEND entry for 5 cycles -> TX_START is withheld until the cycle TX_BUSY falls; no byte is lost or duplicated.
REQ-041 Size=15, buffer[i]=i -> 15 bytes 0x00..0x0E, RD_ADDR never exceeds 14, idx returns to 0.
REQ-042 CLEAR pulsed during WAIT_TX of byte 1 -> BUSY=0 next cycle; no further TX_START; a following START with size=0 after clear gives DONE only.
REQ-043 rst asserted mid-frame, then SIZE_M_EN=1 with REC_DATA=0x02 and START -> all outputs zero during reset; then exactly 2 data bytes are sent.
